// File: rtl/reg_names_pkg.sv
// Shared register-file geometry, RISC-V ABI register names and writeback source tags
// used by the scoreboard, its writeback arbiter and the bench.
package reg_names;

  localparam int REG_COUNT  = 32;
  localparam int REG_SIZE   = $clog2(REG_COUNT);
  localparam int DATA_WIDTH = 32;

  typedef enum logic [REG_SIZE-1:0] {
    zero, ra, sp, gp, tp, t0, t1, t2,
    s0, s1, a0, a1, a2, a3, a4, a5,
    a6, a7, s2, s3, s4, s5, s6, s7,
    s8, s9, s10, s11, t3, t4, t5, t6
  } regName_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/riscv_reg_scoreboard_if.sv
// Valid/ready handshake bundle for the two writeback sources (ALU and memory pipe).
interface riscv_reg_scoreboard_if;

  logic alu_wb_valid;
  logic alu_wb_ready;
  logic mem_wb_valid;
  logic mem_wb_ready;

  modport master (
    output alu_wb_valid, mem_wb_valid,
    input  alu_wb_ready, mem_wb_ready
  );

  modport slave (
    input  alu_wb_valid, mem_wb_valid,
    output alu_wb_ready, mem_wb_ready
  );

endinterface

// File: rtl/riscv_wb_arbiter.sv
// Two-source round-robin writeback arbiter; grants one of ALU/MEM per cycle and
// remembers the last winner so a contending pair alternates, mem first after reset.
module riscv_wb_arbiter
  import reg_names::*;
(
  input  logic    clk,
  input  logic    rstN,
  riscv_reg_scoreboard_if.slave wb,
  output logic    grant_valid,
  output wb_src_t grant_src
);

  wb_src_t last_q, last_d;

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) last_q <= WB_ALU;
    else       last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (grant_valid) last_d = grant_src;
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid     = 1'b0;
    grant_src       = WB_MEM;
    wb.alu_wb_ready = 1'b0;
    wb.mem_wb_ready = 1'b0;
    if (rstN) begin
      if (wb.mem_wb_valid && (!wb.alu_wb_valid || last_q == WB_ALU)) begin
        grant_valid     = 1'b1;
        grant_src       = WB_MEM;
        wb.mem_wb_ready = 1'b1;
      end else if (wb.alu_wb_valid) begin
        grant_valid     = 1'b1;
        grant_src       = WB_ALU;
        wb.alu_wb_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_reg_scoreboard.sv
// Register scoreboard: stalls issue on RAW/WAW hazards, arbitrates ALU/MEM writebacks
// into a registered register-file write port. Define SB_FORWARD_EN for same-cycle bypass.
module riscv_reg_scoreboard
  import reg_names::*;
#(
  parameter int REG_COUNT  = reg_names::REG_COUNT,
  parameter int DATA_WIDTH = reg_names::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [REG_SIZE-1:0]   iss_rs1,
  input  logic [REG_SIZE-1:0]   iss_rs2,
  input  logic [REG_SIZE-1:0]   iss_rd,
  input  logic                  iss_wr,
  input  logic                  alu_wb_valid,
  input  logic [REG_SIZE-1:0]   alu_wb_rd,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [REG_SIZE-1:0]   mem_wb_rd,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  mem_wb_ready,
  output logic                  rf_we,
  output logic [REG_SIZE-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [REG_COUNT-1:0]  busy_vec,
  output logic                  err_spurious
);

  riscv_reg_scoreboard_if wb_if ();

  assign wb_if.alu_wb_valid = alu_wb_valid;
  assign wb_if.mem_wb_valid = mem_wb_valid;
  assign alu_wb_ready       = wb_if.alu_wb_ready;
  assign mem_wb_ready       = wb_if.mem_wb_ready;

  logic    grant_valid;
  wb_src_t grant_src;

  riscv_wb_arbiter u_arb (
    .clk         (clk),
    .rstN        (rstN),
    .wb          (wb_if.slave),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  logic [REG_COUNT-1:0]  busy_q, busy_d, clr_vec, set_vec, busy_view;
  logic                  rf_we_q, rf_we_d, err_q, err_d, iss_fire;
  logic [REG_SIZE-1:0]   rf_waddr_q, rf_waddr_d, g_rd;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d, g_data;

  always_comb begin
    g_rd    = (grant_src == WB_MEM) ? mem_wb_rd   : alu_wb_rd;
    g_data  = (grant_src == WB_MEM) ? mem_wb_data : alu_wb_data;
    clr_vec = '0;
    if (grant_valid) clr_vec[g_rd] = 1'b1;
  end

`ifdef SB_FORWARD_EN
  assign busy_view = busy_q & ~clr_vec;
`else
  assign busy_view = busy_q;
`endif

  always_comb begin
    iss_ready = !busy_view[iss_rs1] && !busy_view[iss_rs2] && !(iss_wr && busy_view[iss_rd]);
    iss_fire  = iss_valid && iss_ready;
    set_vec   = '0;
    if (iss_fire && iss_wr && iss_rd != '0) set_vec[iss_rd] = 1'b1;
  end

  // A same-edge set outranks the clear, so a re-issued rd stays pending.
  always_comb begin
    busy_d     = (busy_q & ~clr_vec) | set_vec;
    busy_d[0]  = 1'b0;
    rf_we_d    = grant_valid && (g_rd != '0);
    rf_waddr_d = grant_valid ? g_rd   : rf_waddr_q;
    rf_wdata_d = grant_valid ? g_data : rf_wdata_q;
    err_d      = err_q || (grant_valid && (g_rd != '0) && !busy_q[g_rd]);
  end

  // NOTE: busy bits live in flops, not a RAM, so they can and must clear on reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign busy_vec     = busy_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_riscv_reg_scoreboard.sv
// Directed bench for riscv_reg_scoreboard: a per-cycle vector table plus hand-written
// sequences for same-cycle bypass and asynchronous reset.
module tb_riscv_reg_scoreboard;

`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        iss_valid, iss_ready, iss_wr;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [4:0]  alu_wb_rd, mem_wb_rd, rf_waddr;
  logic [31:0] alu_wb_data, mem_wb_data, rf_wdata, busy_vec;
  logic        rf_we, err_spurious;

  riscv_reg_scoreboard_if wb_bus ();

  riscv_reg_scoreboard dut (
    .clk          (clk),
    .rstN         (rstN),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_wr       (iss_wr),
    .alu_wb_valid (wb_bus.alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (wb_bus.alu_wb_ready),
    .mem_wb_valid (wb_bus.mem_wb_valid),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (wb_bus.mem_wb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_vec     (busy_vec),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv, iw;
    logic [4:0]  rs1, rs2, rd;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] adat;
    bit          mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    bit          e_ir, e_ar, e_mr, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_busy;
    bit          e_err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    iss_valid           = v.iv;
    iss_wr              = v.iw;
    iss_rs1             = v.rs1;
    iss_rs2             = v.rs2;
    iss_rd              = v.rd;
    wb_bus.alu_wb_valid = v.av;
    alu_wb_rd           = v.ard;
    alu_wb_data         = v.adat;
    wb_bus.mem_wb_valid = v.mv;
    mem_wb_rd           = v.mrd;
    mem_wb_data         = v.mdat;
  endtask

  localparam logic [31:0] B10 = 32'h0000_0400;
  localparam logic [31:0] B11 = 32'h0000_0800;

  vec_t vecs[20];
  vec_t idle;

  initial begin
    logic [4:0] r_a0, r_a1, r_s2, r_s3, r_t3, r_t6;
    r_a0 = reg_names::a0;
    r_a1 = reg_names::a1;
    r_s2 = reg_names::s2;
    r_s3 = reg_names::s3;
    r_t3 = reg_names::t3;
    r_t6 = reg_names::t6;

    idle = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 0};
    //          iv iw rs1  rs2  rd     av ard   adat          mv mrd   mdat          ir    ar mr we wa    wd            busy            err
    vecs[0]  = '{0,0, 0,   0,   0,     0, 0,    0,            0, 0,    0,            1,    0, 0, 0, 0,    0,            0,              0};
    vecs[1]  = '{1,1, 0,   0,   r_a0,  0, 0,    0,            0, 0,    0,            1,    0, 0, 0, 0,    0,            B10,            0};
    vecs[2]  = '{1,1, r_a0,0,   r_a1,  0, 0,    0,            0, 0,    0,            0,    0, 0, 0, 0,    0,            B10,            0};
    vecs[3]  = '{1,1, r_a0,0,   r_a1,  1, r_a0, 32'h11111111, 0, 0,    0,            FWD,  1, 0, 1, r_a0, 32'h11111111, FWD ? B11 : 0, 0};
    vecs[4]  = '{!FWD,1, r_a0,0, r_a1, 0, 0,    0,            0, 0,    0,            !FWD, 0, 0, 0, 0,    0,            B11,            0};
    vecs[5]  = '{0,0, 0,   0,   0,     1, r_a1, 32'h22222222, 0, 0,    0,            1,    1, 0, 1, r_a1, 32'h22222222, 0,              0};
    vecs[6]  = '{0,0, 0,   0,   0,     0, 0,    0,            1, 0,    32'hDEADBEEF, 1,    0, 1, 0, 0,    0,            0,              0};
    vecs[7]  = '{0,0, 0,   0,   0,     1, r_t3, 32'hCAFE0028, 0, 0,    0,            1,    1, 0, 1, r_t3, 32'hCAFE0028, 0,              1};
    vecs[8]  = '{0,0, 0,   0,   0,     0, 0,    0,            0, 0,    0,            1,    0, 0, 0, 0,    0,            0,              1};
    vecs[9]  = '{0,0, 0,   0,   0,     1, r_s2, 32'hA0000001, 1, r_s3, 32'hB0000001, 1,    0, 1, 1, r_s3, 32'hB0000001, 0,              1};
    vecs[10] = '{0,0, 0,   0,   0,     1, r_s2, 32'hA0000001, 1, r_s3, 32'hB0000002, 1,    1, 0, 1, r_s2, 32'hA0000001, 0,              1};
    vecs[11] = '{0,0, 0,   0,   0,     1, r_s2, 32'hA0000002, 1, r_s3, 32'hB0000002, 1,    0, 1, 1, r_s3, 32'hB0000002, 0,              1};
    vecs[12] = '{0,0, 0,   0,   0,     1, r_s2, 32'hA0000002, 1, r_s3, 32'hB0000003, 1,    1, 0, 1, r_s2, 32'hA0000002, 0,              1};
    vecs[13] = '{0,0, 0,   0,   0,     0, 0,    0,            0, 0,    0,            1,    0, 0, 0, 0,    0,            0,              1};
    vecs[14] = '{1,1, 0,   0,   0,     0, 0,    0,            0, 0,    0,            1,    0, 0, 0, 0,    0,            0,              1};
    vecs[15] = '{1,1, 0,   0,   r_t6,  0, 0,    0,            0, 0,    0,            1,    0, 0, 0, 0,    0,            32'h80000000,   1};
    vecs[16] = '{1,0, 0,   r_t6,0,     0, 0,    0,            0, 0,    0,            0,    0, 0, 0, 0,    0,            32'h80000000,   1};
    vecs[17] = '{1,1, 0,   0,   r_t6,  0, 0,    0,            0, 0,    0,            0,    0, 0, 0, 0,    0,            32'h80000000,   1};
    vecs[18] = '{1,0, 0,   0,   r_t6,  0, 0,    0,            0, 0,    0,            1,    0, 0, 0, 0,    0,            32'h80000000,   1};
    vecs[19] = '{0,0, 0,   0,   0,     0, 0,    0,            1, r_t6, 32'h00000031, 1,    0, 1, 1, r_t6, 32'h00000031, 0,              1};

    // Reset asserted with a writeback pending: readies must stay low.
    rstN = 1'b0;
    drive(idle);
    wb_bus.alu_wb_valid = 1'b1;
    wb_bus.mem_wb_valid = 1'b1;
    #2;
    check("rst_alu_ready", 32'(wb_bus.alu_wb_ready), 0);
    check("rst_mem_ready", 32'(wb_bus.mem_wb_ready), 0);
    check("rst_busy", busy_vec, 0);
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_err", 32'(err_spurious), 0);
    @(negedge clk);
    drive(idle);
    rstN = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_iss_ready", i), 32'(iss_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d_alu_ready", i), 32'(wb_bus.alu_wb_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d_mem_ready", i), 32'(wb_bus.mem_wb_ready), 32'(vecs[i].e_mr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_wa));
        check($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wd);
      end
      check($sformatf("v%0d_busy", i), busy_vec, vecs[i].e_busy);
      check($sformatf("v%0d_err", i), 32'(err_spurious), 32'(vecs[i].e_err));
    end

    // Same-cycle bypass: busy[5] cleared by this cycle's grant while rs2=5 asks to issue.
    @(negedge clk);
    drive(idle);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd5;
    @(posedge clk); #1;
    check("fwd_busy_set", busy_vec, 32'h20);
    @(negedge clk);
    drive(idle);
    iss_valid = 1'b1; iss_rs2 = 5'd5;
    wb_bus.alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h55;
    #1;
    check("fwd_iss_ready", 32'(iss_ready), 32'(FWD));
    check("fwd_alu_ready", 32'(wb_bus.alu_wb_ready), 1);
    @(posedge clk); #1;
    check("fwd_busy_clr", busy_vec, 0);
    check("fwd_rf_waddr", 32'(rf_waddr), 5);
    @(negedge clk);
    wb_bus.alu_wb_valid = 1'b0;
    #1;
    check("fwd_iss_ready_next", 32'(iss_ready), 1);

    // Asynchronous reset mid-operation with busy[8], busy[9] set and a writeback pending.
    @(negedge clk);
    drive(idle);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd8;
    @(negedge clk);
    iss_rd = 5'd9;
    @(negedge clk);
    drive(idle);
    wb_bus.alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h77;
    @(negedge clk);
    drive(idle);
    wb_bus.mem_wb_valid = 1'b1; mem_wb_rd = 5'd9; mem_wb_data = 32'h99;
    #1;
    check("pre_rst_busy", busy_vec, 32'h300);
    check("pre_rst_rf_we", 32'(rf_we), 1);
    check("pre_rst_mem_ready", 32'(wb_bus.mem_wb_ready), 1);
    #1;
    rstN = 1'b0;
    #1;
    check("arst_busy", busy_vec, 0);
    check("arst_rf_we", 32'(rf_we), 0);
    check("arst_rf_waddr", 32'(rf_waddr), 0);
    check("arst_rf_wdata", rf_wdata, 0);
    check("arst_err", 32'(err_spurious), 0);
    check("arst_mem_ready", 32'(wb_bus.mem_wb_ready), 0);
    @(negedge clk);
    drive(idle);
    rstN = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", busy_vec, 0);
    check("post_rst_rf_we", 32'(rf_we), 0);
    check("post_rst_iss_ready", 32'(iss_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
